// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: staggered multi-channel reset sequencer with completed-sequence counter.
// Rev 1.0 -- optional idle auto re-trigger enabled by defining RST_SEQ_AUTO_EN.
`default_nettype none

module rst_seq_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int PULSE_CYCLES = 3,
  parameter int STAGGER      = 2,
  parameter int CNT_W        = 8,
  parameter int AUTO_PERIOD  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trig_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              trig_ack,
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  reset_count
);

  localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int STAG_W  = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [STAG_W-1:0]  STAG_LOAD  = STAG_W'((STAGGER > 0) ? (STAGGER - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_RELEASE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  if (NUM_CH < 1 || NUM_CH > 32 || PULSE_CYCLES < 1 || STAGGER < 0 ||
      CNT_W < 1 || AUTO_PERIOD < 1) begin : g_param_check
    $error("rst_seq_ctrl: parameter out of range");
  end

  state_t              state;
  logic [NUM_CH-1:0]   pending;
  logic [PULSE_W-1:0]  pulse_cnt;
  logic [STAG_W-1:0]   stag_cnt;
  logic                zero_seq;
  logic                auto_fire;
  logic [NUM_CH-1:0]   pend_lsb_clr;
  logic [NUM_CH-1:0]   first_release;
  logic [CNT_W-1:0]    count_inc;

  assign rst_out       = pending;
  assign pend_lsb_clr  = pending & (pending - NUM_CH'(1));
  assign first_release = (STAGGER == 0) ? '0 : pend_lsb_clr;
  assign count_inc     = (reset_count == '1) ? reset_count : reset_count + CNT_W'(1);

`ifdef RST_SEQ_AUTO_EN
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] idle_cnt;

  assign auto_fire = (state == S_IDLE) && !trig_req && (idle_cnt == AUTO_LAST);

  always_ff @(posedge clk) begin
    if (reset || state != S_IDLE || trig_req || auto_fire) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + AUTO_W'(1);
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_ASSERT;
      pending     <= '1;
      pulse_cnt   <= PULSE_LOAD;
      stag_cnt    <= '0;
      reset_count <= '0;
      trig_ack    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b1;
      zero_seq    <= 1'b0;
    end else begin
      trig_ack <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig_req) begin
            trig_ack  <= 1'b1;
            pending   <= ch_mask;
            pulse_cnt <= PULSE_LOAD;
            busy      <= 1'b1;
            if (ch_mask == '0) begin
              // Empty mask: skip straight to DONE; done is reported on the way out.
              state    <= S_DONE;
              zero_seq <= 1'b1;
            end else begin
              state <= S_ASSERT;
            end
          end else if (auto_fire) begin
            pending   <= '1;
            pulse_cnt <= PULSE_LOAD;
            busy      <= 1'b1;
            state     <= S_ASSERT;
          end
        end

        S_ASSERT: begin
          if (pulse_cnt == '0) begin
            pending  <= first_release;
            stag_cnt <= STAG_LOAD;
            if (first_release == '0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              reset_count <= count_inc;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            pulse_cnt <= pulse_cnt - PULSE_W'(1);
          end
        end

        S_RELEASE: begin
          if (stag_cnt == '0) begin
            pending  <= pend_lsb_clr;
            stag_cnt <= STAG_LOAD;
            if (pend_lsb_clr == '0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              reset_count <= count_inc;
            end
          end else begin
            stag_cnt <= stag_cnt - STAG_W'(1);
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          done     <= zero_seq;
          zero_seq <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
